// File: rtl/execute_muldiv_unit_if.sv
// Handshake and result bus between the ID/EX pipeline register, the
// multiply/divide unit and the EX/MEM register.
interface execute_muldiv_unit_if #(
    parameter int XLEN           = 32,
    parameter int REG_ADDR_WIDTH = 5
);
    logic                      start;
    logic                      flush;
    logic [2:0]                operation_in;
    logic [XLEN-1:0]           read_data_1;
    logic [XLEN-1:0]           read_data_2;
    logic [REG_ADDR_WIDTH-1:0] write_register_in;
    logic [XLEN-1:0]           result;
    logic                      result_valid;
    logic [REG_ADDR_WIDTH-1:0] write_register_out;
    logic                      write_out;
    logic                      busy;
    logic                      stall_out;

    // Pipeline side: presents the instruction, consumes the result.
    modport master (
        output start, flush, operation_in, read_data_1, read_data_2, write_register_in,
        input  result, result_valid, write_register_out, write_out, busy, stall_out
    );

    // Unit side.
    modport slave (
        input  start, flush, operation_in, read_data_1, read_data_2, write_register_in,
        output result, result_valid, write_register_out, write_out, busy, stall_out
    );
endinterface

// File: rtl/execute_muldiv_unit.sv
// Iterative RV32M multiply/divide unit for the Execute stage.
// Radix-2 shift-add multiply and restoring divide, one bit per cycle,
// on operand magnitudes with a sign fix applied when the result is loaded.
//
// state | meaning
// IDLE  | waiting for an M-extension instruction in ID/EX
// BUSY  | one multiply/divide iteration per cycle, pipeline stalled
// DONE  | one-cycle result pulse toward EX/MEM
module execute_muldiv_unit #(
    parameter int XLEN           = 32,
    parameter int REG_ADDR_WIDTH = 5
) (
    input  logic                 clk,
    input  logic                 reset,
    execute_muldiv_unit_if.slave mdu
);
    localparam int              CNT_W   = $clog2(XLEN) + 1;
    localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t                    state_q, state_d;
    logic [2:0]                op_q;
    logic [REG_ADDR_WIDTH-1:0] rd_q;
    logic [REG_ADDR_WIDTH-1:0] rd_out_q;
    logic                      neg_a_q, neg_b_q;
    logic [XLEN-1:0]           acc_hi_q;   // product high half / partial remainder
    logic [XLEN-1:0]           acc_lo_q;   // multiplier / dividend shifting into quotient
    logic [XLEN-1:0]           mag_b_q;    // multiplicand / divisor magnitude
    logic [XLEN-1:0]           result_q;
    logic [CNT_W-1:0]          count_q;

    logic                      accept;
    logic                      signed_a_in, signed_b_in;
    logic                      neg_a_in, neg_b_in;
    logic [XLEN-1:0]           mag_a_in, mag_b_in;
    logic                      div_zero_in, overflow_in, fast_in;
    logic [XLEN-1:0]           fast_result;
    logic                      last_iter;

    logic [XLEN:0]             mul_sum;
    logic [XLEN:0]             rem_shift;
    logic                      div_borrow;
    logic [XLEN-1:0]           div_diff;
    logic [XLEN-1:0]           step_hi, step_lo;
    logic [2*XLEN-1:0]         product, product_fix;
    logic [XLEN-1:0]           quot_fix, rem_fix;
    logic [XLEN-1:0]           final_result;

    assign accept      = (state_q == IDLE) && mdu.start && !mdu.flush;
    assign last_iter   = (state_q == BUSY) && (count_q == CNT_W'(XLEN - 1));

    // MULH, MULHSU, DIV and REM treat rs1 as signed; MULHSU keeps rs2 unsigned.
    assign signed_a_in = (mdu.operation_in == 3'd1) || (mdu.operation_in == 3'd2) ||
                         (mdu.operation_in == 3'd4) || (mdu.operation_in == 3'd6);
    assign signed_b_in = (mdu.operation_in == 3'd1) || (mdu.operation_in == 3'd4) ||
                         (mdu.operation_in == 3'd6);
    assign neg_a_in    = signed_a_in && mdu.read_data_1[XLEN-1];
    assign neg_b_in    = signed_b_in && mdu.read_data_2[XLEN-1];
    assign mag_a_in    = neg_a_in ? -mdu.read_data_1 : mdu.read_data_1;
    assign mag_b_in    = neg_b_in ? -mdu.read_data_2 : mdu.read_data_2;

    assign div_zero_in = mdu.operation_in[2] && (mdu.read_data_2 == '0);
    assign overflow_in = mdu.operation_in[2] && !mdu.operation_in[0] &&
                         (mdu.read_data_1 == INT_MIN) && (mdu.read_data_2 == '1);
    assign fast_in     = div_zero_in || overflow_in;

    // Architectural results for divide-by-zero and signed overflow (bit 1 selects REM/REMU).
    always_comb begin
        fast_result = '0;
        if (div_zero_in) begin
            fast_result = mdu.operation_in[1] ? mdu.read_data_1 : '1;
        end else begin
            fast_result = mdu.operation_in[1] ? '0 : INT_MIN;
        end
    end

    // One multiply or restoring-divide iteration computed from the current registers.
    always_comb begin
        mul_sum    = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, mag_b_q} : '0);
        rem_shift  = {acc_hi_q, acc_lo_q[XLEN-1]};
        div_borrow = rem_shift < {1'b0, mag_b_q};
        div_diff   = rem_shift[XLEN-1:0] - mag_b_q;
        if (op_q[2]) begin
            step_hi = div_borrow ? rem_shift[XLEN-1:0] : div_diff;
            step_lo = {acc_lo_q[XLEN-2:0], !div_borrow};
        end else begin
            step_hi = mul_sum[XLEN:1];
            step_lo = {mul_sum[0], acc_lo_q[XLEN-1:1]};
        end
    end

    // Sign fix and result selection applied to the last iteration's outputs.
    always_comb begin
        product      = {step_hi, step_lo};
        product_fix  = (neg_a_q ^ neg_b_q) ? -product : product;
        quot_fix     = (neg_a_q ^ neg_b_q) ? -step_lo : step_lo;
        rem_fix      = neg_a_q ? -step_hi : step_hi;
        final_result = '0;
        case (op_q)
            3'd0:                final_result = product_fix[XLEN-1:0];
            3'd1, 3'd2, 3'd3:    final_result = product_fix[2*XLEN-1:XLEN];
            3'd4, 3'd5:          final_result = quot_fix;
            default:             final_result = rem_fix;
        endcase
    end

    // Next-state logic; flush wins over the final iteration.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = fast_in ? DONE : BUSY;
                end
            end
            BUSY: begin
                if (mdu.flush) begin
                    state_d = IDLE;
                end else if (last_iter) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Operand capture, iteration datapath and result registers.
    always_ff @(posedge clk) begin
        if (!reset) begin
            op_q     <= '0;
            rd_q     <= '0;
            rd_out_q <= '0;
            neg_a_q  <= 1'b0;
            neg_b_q  <= 1'b0;
            acc_hi_q <= '0;
            acc_lo_q <= '0;
            mag_b_q  <= '0;
            result_q <= '0;
            count_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        op_q     <= mdu.operation_in;
                        rd_q     <= mdu.write_register_in;
                        neg_a_q  <= neg_a_in;
                        neg_b_q  <= neg_b_in;
                        acc_hi_q <= '0;
                        acc_lo_q <= mag_a_in;
                        mag_b_q  <= mag_b_in;
                        count_q  <= '0;
                        if (fast_in) begin
                            result_q <= fast_result;
                            rd_out_q <= mdu.write_register_in;
                        end
                    end
                end
                BUSY: begin
                    if (!mdu.flush) begin
                        acc_hi_q <= step_hi;
                        acc_lo_q <= step_lo;
                        count_q  <= count_q + 1'b1;
                        if (last_iter) begin
                            result_q <= final_result;
                            rd_out_q <= rd_q;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign mdu.result             = result_q;
    assign mdu.write_register_out = rd_out_q;
    assign mdu.result_valid       = (state_q == DONE);
    assign mdu.write_out          = (state_q == DONE) && (rd_out_q != '0);
    assign mdu.busy               = (state_q != IDLE);
    assign mdu.stall_out          = (state_q == BUSY) || accept;
endmodule
